// File: rtl/gameover_banner_ctrl_if.sv
// Banner controller bus: frame/game inputs in, sprite position and gate out.
// master = game/timing side, slave = gameover_banner_ctrl.
interface gameover_banner_ctrl_if;
  logic       vsync;
  logic       game_over;
  logic       restart;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic       visible;
  logic       done;

  modport master (
    output vsync, game_over, restart,
    input  sprite_x, sprite_y, visible, done
  );

  modport slave (
    input  vsync, game_over, restart,
    output sprite_x, sprite_y, visible, done
  );
endinterface

// File: rtl/gameover_banner_ctrl.sv
// GAME OVER banner slide/blink/hold controller, one update per frame.
// Define GAMEOVER_BLINK_EN to build the blink counter; otherwise BLINK is steady.
module gameover_banner_ctrl #(
  parameter int SPRITE_W     = 172,
  parameter int H_ACTIVE     = 640,
  parameter int START_Y      = 0,
  parameter int TARGET_Y     = 232,
  parameter int STEP         = 4,
`ifdef GAMEOVER_BLINK_EN
  parameter int BLINK_FRAMES = 8,
`endif
  parameter int HOLD_FRAMES  = 64
) (
  input logic clk,
  input logic reset,
  gameover_banner_ctrl_if.slave bus
);

  localparam logic [9:0] X_POS = 10'((H_ACTIVE - SPRITE_W) / 2);
  localparam int FW = $clog2(HOLD_FRAMES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SLIDE = 2'd1;
  localparam logic [1:0] BLINK = 2'd2;
  localparam logic [1:0] READY = 2'd3;

  logic          vs_s1;
  logic          vs_s2;
  logic          vs_s3;
  logic          frame_tick;
  logic          go_r;
  logic          go_q;
  logic          start;
  logic [1:0]    state;
  logic [9:0]    y_q;
  logic          vis_q;
  logic          done_q;
  logic [FW-1:0] frame_cnt;
  logic [10:0]   y_sum;
  logic          frame_last;

`ifdef GAMEOVER_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_s1      <= 1'b0;
      vs_s2      <= 1'b0;
      vs_s3      <= 1'b0;
      frame_tick <= 1'b0;
      go_r       <= 1'b0;
      go_q       <= 1'b0;
    end else begin
      vs_s1      <= bus.vsync;
      vs_s2      <= vs_s1;
      vs_s3      <= vs_s2;
      frame_tick <= vs_s3 & ~vs_s2;
      go_r       <= bus.game_over;
      go_q       <= go_r;
    end
  end

  assign start      = go_r & ~go_q;
  // 11-bit sum so a step past 1023 cannot wrap below the target
  assign y_sum      = {1'b0, y_q} + 11'(STEP);
  assign frame_last = (frame_cnt == FW'(HOLD_FRAMES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      y_q       <= 10'(START_Y);
      vis_q     <= 1'b0;
      done_q    <= 1'b0;
      frame_cnt <= '0;
`ifdef GAMEOVER_BLINK_EN
      blink_cnt <= '0;
`endif
    end else if (bus.restart) begin
      state     <= IDLE;
      y_q       <= 10'(START_Y);
      vis_q     <= 1'b0;
      done_q    <= 1'b0;
      frame_cnt <= '0;
`ifdef GAMEOVER_BLINK_EN
      blink_cnt <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SLIDE;
            vis_q <= 1'b1;
          end
        end
        SLIDE: begin
          if (frame_tick) begin
            if (y_sum >= 11'(TARGET_Y)) begin
              y_q       <= 10'(TARGET_Y);
              state     <= BLINK;
              frame_cnt <= '0;
`ifdef GAMEOVER_BLINK_EN
              blink_cnt <= '0;
`endif
            end else begin
              y_q <= y_sum[9:0];
            end
          end
        end
        BLINK: begin
          if (frame_tick) begin
            frame_cnt <= frame_cnt + FW'(1);
`ifdef GAMEOVER_BLINK_EN
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
              vis_q     <= ~vis_q;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + BW'(1);
            end
`endif
            if (frame_last) begin
              state  <= READY;
              vis_q  <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        READY: begin
          vis_q  <= 1'b1;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sprite_x = X_POS;
  assign bus.sprite_y = y_q;
  assign bus.visible  = vis_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_gameover_banner_ctrl.sv
// Randomized-timing bench for gameover_banner_ctrl against a frame-count model.
// Second instance runs with STEP = 5 to cover the clamp on the final tick.
module tb_gameover_banner_ctrl;

  localparam int X_POS    = 234;
  localparam int START_Y  = 0;
  localparam int TARGET_Y = 232;
  localparam int BLINK    = 8;
  localparam int HOLD     = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gameover_banner_ctrl_if bus ();
  gameover_banner_ctrl_if bus5 ();

  gameover_banner_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  gameover_banner_ctrl #(.STEP(5)) u_dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // model: slide position after n ticks, clamped to the target
  function automatic int slide_y(input int n, input int step);
    int y;
    y = START_Y + n * step;
    return (y > TARGET_Y) ? TARGET_Y : y;
  endfunction

  // model: visibility after k ticks spent in the blink phase
  function automatic int blink_vis(input int k);
`ifdef GAMEOVER_BLINK_EN
    if (k >= HOLD) return 1;
    return ((k / BLINK) % 2 == 0) ? 1 : 0;
`else
    return (k >= 0) ? 1 : 0;
`endif
  endfunction

  task automatic chk_out(input string tag, input int y, input int vis,
                         input int dn);
    chk({tag, ".x"}, 32'(bus.sprite_x), X_POS);
    chk({tag, ".y"}, 32'(bus.sprite_y), y);
    chk({tag, ".vis"}, 32'(bus.visible), vis);
    chk({tag, ".done"}, 32'(bus.done), dn);
  endtask

  task automatic vsync_pulse();
    bus.vsync  = 1'b0;
    bus5.vsync = 1'b0;
    repeat ($urandom_range(2, 6)) @(negedge clk);
    bus.vsync  = 1'b1;
    bus5.vsync = 1'b1;
    repeat ($urandom_range(6, 12)) @(negedge clk);
  endtask

  task automatic rise_game_over();
    bus.game_over = 1'b0;
    repeat (3) @(negedge clk);
    bus.game_over = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask

  task automatic run_slide(input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      vsync_pulse();
      chk_out(tag, slide_y(i, 4), 1, 0);
    end
  endtask

  initial begin
    int k;
    int n;
    reset          = 1'b0;
    bus.vsync      = 1'b1;
    bus.game_over  = 1'b0;
    bus.restart    = 1'b0;
    bus5.vsync     = 1'b1;
    bus5.game_over = 1'b0;
    bus5.restart   = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("rst", START_Y, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      vsync_pulse();
      chk_out("idle", START_Y, 0, 0);
    end

    rise_game_over();
    chk_out("slide0", START_Y, 1, 0);
    run_slide(58, "slide");

    for (int i = 1; i <= HOLD; i++) begin
      vsync_pulse();
      chk_out("blink", TARGET_Y, blink_vis(i), (i == HOLD) ? 1 : 0);
    end

    for (int i = 0; i < 3; i++) begin
      vsync_pulse();
      chk_out("ready", TARGET_Y, 1, 1);
    end

    pulse_restart();
    chk_out("rst_ready", START_Y, 0, 0);
    for (int i = 0; i < 3; i++) begin
      vsync_pulse();
      chk_out("no_retrig", START_Y, 0, 0);
    end

    // restart lands in the same cycle as a frame tick
    rise_game_over();
    run_slide(25, "slide100");
    bus.vsync = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    chk_out("rst_tick", START_Y, 0, 0);
    bus.vsync = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vsync_pulse();
      chk_out("rst_tick_hold", START_Y, 0, 0);
    end

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 80);
      rise_game_over();
      for (int i = 1; i <= n; i++) begin
        vsync_pulse();
        if (i <= 58) chk_out("rnd_slide", slide_y(i, 4), 1, 0);
        else chk_out("rnd_blink", TARGET_Y, blink_vis(i - 58), 0);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      pulse_restart();
      chk_out("rnd_rst", START_Y, 0, 0);
    end

    // asynchronous reset while blinking
    rise_game_over();
    run_slide(58, "pre_arst");
    k = $urandom_range(1, 20);
    for (int i = 1; i <= k; i++) begin
      vsync_pulse();
      chk_out("pre_arst_blink", TARGET_Y, blink_vis(i), 0);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    bus.game_over = 1'b0;
    #1;
    chk_out("arst", START_Y, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vsync_pulse();
      chk_out("post_arst", START_Y, 0, 0);
    end
    bus.game_over = 1'b1;
    repeat (4) @(negedge clk);
    run_slide(2, "rearm");

    // STEP = 5 instance: clamps on tick 47
    bus5.game_over = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 47; i++) begin
      vsync_pulse();
      chk("step5.y", 32'(bus5.sprite_y), slide_y(i, 5));
      chk("step5.vis", 32'(bus5.visible), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gameover_banner_ctrl.md
# gameover_banner_ctrl

Frame-rate motion and blink controller for the 172×16 "GAME OVER" banner sprite. Sits directly upstream of the banner sprite renderer: drives its `sprite_x`/`sprite_y` position inputs and a `visible` gate that the pixel mux ANDs with the renderer's `drawing`. On a game-over event the banner slides down from the top edge to screen centre, blinks for a fixed number of frames, then holds steady until restart.

## Interface
- `SPRITE_W`, 172: banner width in pixels.
- `H_ACTIVE`, 640: active line width; `X_POS` = (H_ACTIVE − SPRITE_W)/2 = 234.
- `START_Y`, 0: initial row of the slide.
- `TARGET_Y`, 232: final row of the slide.
- `STEP`, 4: rows moved per frame during the slide.
- `BLINK_FRAMES`, 8: frames per blink half-period.
- `HOLD_FRAMES`, 64: total frames spent in BLINK.
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-low reset.
- `vsync`  in  1  raw vsync from the timing generator; falling edge marks the frame boundary.
- `game_over`  in  1  level from game logic; a rising edge starts the sequence.
- `restart`  in  1  single-cycle pulse; aborts to IDLE.
- `sprite_x`  out  10  banner column, to renderer `sprite_x`.
- `sprite_y`  out  10  banner row, to renderer `sprite_y`.
- `visible`  out  1  banner enable for the pixel mux.
- `done`  out  1  high in READY.

## Operation
- `vsync` passes through a 2-FF synchroniser; a falling edge of the synchronised signal produces a one-cycle `frame_tick`.
- `game_over` is registered once; `start` = game_over & ~game_over_q.
- States: IDLE, SLIDE, BLINK, READY.
- IDLE: sprite_y = START_Y, visible = 0, done = 0. On `start`, go to SLIDE with visible = 1.
- SLIDE: on each `frame_tick`, if sprite_y + STEP ≥ TARGET_Y then set sprite_y = TARGET_Y, go to BLINK, and clear the frame and blink counters; otherwise sprite_y += STEP. The comparison is 11 bits wide to avoid wrap.
- BLINK: on each `frame_tick`, frame_cnt increments. `visible` toggles each time blink_cnt reaches BLINK_FRAMES−1, after which blink_cnt clears. When frame_cnt reaches HOLD_FRAMES−1, go to READY with visible = 1.
- READY: visible = 1, done = 1. Ignores `frame_tick` and `start`.
- `restart` in any state: next cycle the block is in IDLE with IDLE outputs. If `restart` and `start` occur in the same cycle, `restart` wins.
- `sprite_x` is the constant X_POS after reset.
- `start` is ignored outside IDLE.

## Timing
- Reset values: sprite_x = X_POS, sprite_y = START_Y, visible = 0, done = 0, state = IDLE, all counters 0.
- Vsync falling edge to `frame_tick`: 3 clk (two synchroniser stages plus the edge register).
- All outputs are registered and change only on the cycle after `frame_tick`, `start`, or `restart`.
- The renderer latches position on vsync negedge, before this update lands. The position therefore lags by one frame by design, and the banner never moves mid-frame.
- `game_over` rising edge to the SLIDE state: 2 clk.
- Slide duration with defaults: 58 frame ticks (232/4). The final tick lands exactly on TARGET_Y; a non-multiple STEP clamps on the last tick.
- Reset assertion mid-sequence forces reset values immediately (asynchronous). Release of `reset` must be synchronous to `clk` at system level.

## Configuration
- `GAMEOVER_BLINK_EN` defined: BLINK toggles `visible` as described.
- `GAMEOVER_BLINK_EN` undefined: the blink counter is not built, and `visible` stays 1 throughout BLINK. BLINK still lasts HOLD_FRAMES frames before READY.

## Test plan
- Reset, then 5 vsync pulses with game_over = 0 -> sprite_x = 234, sprite_y = 0, visible = 0, done = 0 throughout.
- game_over rises, then 58 vsync pulses -> sprite_y reads 4, 8, …, 232 after each tick; state enters BLINK on the 58th tick.
- Blink enabled, 64 further ticks -> `visible` toggles after ticks 8, 16, …; after tick 64, done = 1 and visible = 1. With the macro undefined, `visible` stays 1 throughout.
- STEP = 5, TARGET_Y = 232 -> after 46 ticks sprite_y = 230; tick 47 clamps to 232, not 235.
- `restart` pulse mid-SLIDE at sprite_y = 100, coincident with a `frame_tick` -> next cycle IDLE, sprite_y = 0, visible = 0; game_over still high does not retrigger.
- Reset asserted in BLINK between clock edges -> outputs at reset values before the next clk edge; after release, remains in IDLE until a new game_over rising edge.
